// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word-aligned reads to instruction memory and presents
// fetched instructions to the IF/ID register. It handles stalls, branch and exception
// redirects, and responses that are still outstanding when a redirect arrives.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDiscard,
    StHold
  } state_e;

  state_e      r_state;
  logic [31:0] r_target;

  logic        w_redirect;
  logic [31:0] w_target;

  // Select the redirect target. Flush wins over branch, and the low address bits are cleared.
  always_comb begin
    w_redirect = flush | branch_flag_i;
    w_target   = (flush ? new_pc : branch_target_addr_i) & 32'hFFFF_FFFC;
  end

  // Fetch FSM. Every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_target <= 32'h0;
      rom_req  <= 1'b0;
      rom_addr <= RESET_PC;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
      if_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // An ack seen here belongs to a request abandoned by reset, so it is ignored.
          r_state  <= StFetch;
          rom_req  <= 1'b1;
          rom_addr <= RESET_PC;
        end
        StFetch: begin
          if (w_redirect) begin
            if_valid <= 1'b0;
            if (rom_ack) begin
              rom_addr <= w_target;
            end else begin
              // The request stays outstanding. Its response is dropped when it arrives.
              r_state  <= StDiscard;
              r_target <= w_target;
            end
          end else if (rom_ack) begin
            if_pc    <= rom_addr;
            if_inst  <= rom_data;
            if_valid <= 1'b1;
            if (stall) begin
              r_state <= StHold;
              rom_req <= 1'b0;
            end else begin
              rom_addr <= rom_addr + 32'd4;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        StDiscard: begin
          if (w_redirect) begin
            r_target <= w_target;
          end
          if (rom_ack) begin
            r_state  <= StFetch;
            rom_addr <= w_redirect ? w_target : r_target;
          end
        end
        StHold: begin
          if (w_redirect) begin
            r_state  <= StFetch;
            rom_req  <= 1'b1;
            rom_addr <= w_target;
            if_valid <= 1'b0;
          end else if (!stall) begin
            r_state  <= StFetch;
            rom_req  <= 1'b1;
            rom_addr <= if_pc + 32'd4;
            if_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
      // An exception squashes whatever is being presented, in every state.
      if (flush) begin
        if_valid <= 1'b0;
        if_inst  <= 32'h0;
      end
    end
  end

endmodule
